mem_port_arbiter: RTL

- Shares one single-ported, variable-latency unified memory between the CPU's instruction-fetch port (IF stage) and data port (MEM stage, load/store).
- Sits between the 5-stage pipeline and the memory backend, and provides per-port stall signals that the pipeline uses to freeze.
- Data accesses take priority, with a starvation guard that forces an instruction fetch after a bounded run of data grants.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between
// the instruction-fetch port and the data port of a 5-stage pipeline.
// Data accesses win ties; a starvation counter forces a fetch after a bounded
// run of data grants while a fetch is waiting.
//
// Handshake: a port raises req (with stable address/controls) and holds it
// until its one-cycle ready pulse; rdata is valid while ready is high. On the
// backend, mem_req and its address/controls stay constant until the one-cycle
// mem_ack, which also qualifies mem_rdata. mem_ack outside ISSUE is ignored.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    output logic                  i_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  d_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_n;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_n;
    logic       take_d;
    logic       take_i;

    // Stall is the only combinational output: a pending request not yet served.
    assign i_stall = i_req & ~i_ready;
    assign d_stall = d_req & ~d_ready;

    // Next state, grant decision (only in IDLE) and starvation counter update.
    always_comb begin
        state_n      = state;
        take_d       = 1'b0;
        take_i       = 1'b0;
        starve_cnt_n = starve_cnt;
        case (state)
            IDLE: begin
                // Data wins unless a waiting fetch has already seen LIMIT data grants.
                if (d_req && !(i_req && (starve_cnt == LIMIT))) begin
                    take_d  = 1'b1;
                    state_n = ISSUE;
                    if (i_req) begin
                        starve_cnt_n = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
                    end else begin
                        starve_cnt_n = 4'd0;
                    end
                end else if (i_req) begin
                    take_i       = 1'b1;
                    state_n      = ISSUE;
                    starve_cnt_n = 4'd0;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                // Requests are deliberately not sampled here; ready is high this cycle.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_cnt_n;
        end
    end

    // Registered backend request, grant owner, ready pulses and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_d   <= 1'b0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        grant_d   <= 1'b1;
                    end else if (take_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                        grant_d   <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (grant_d) begin
                            d_ready <= 1'b1;
                            // A store leaves the last load value in place.
                            if (!mem_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
